// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU and FSM encodings for the control_unit slice.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_OR     = 4'h4;
    localparam logic [3:0] OP_XOR    = 4'h5;
    localparam logic [3:0] OP_MOV    = 4'h6;
    localparam logic [3:0] OP_CLR    = 4'h7;
    localparam logic [3:0] OP_CLRALL = 4'h8;
    localparam logic [3:0] OP_JMP    = 4'h9;
    localparam logic [3:0] OP_JZ     = 4'hA;
    localparam logic [3:0] OP_JNZ    = 4'hB;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_PASS_B = 3'd5;

    localparam logic [1:0] JC_ALWAYS = 2'd0;
    localparam logic [1:0] JC_Z      = 2'd1;
    localparam logic [1:0] JC_NZ     = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RA_MSB  = 11;
    localparam int unsigned RA_LSB  = 9;
    localparam int unsigned RB_MSB  = 8;
    localparam int unsigned RB_LSB  = 6;
    localparam int unsigned IMM_BIT = 5;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder; outputs are ungated, the caller qualifies them with RUN.
import ctrl_pkg::*;

module instr_decoder (
    input  logic [3:0] op,
    input  logic       imm,
    output logic       load,
    output logic       clr_all,
    output logic       wb_zero,
    output logic [2:0] alu_op,
    output logic       mb_select,
    output logic       is_jump,
    output logic [1:0] jump_cond,
    output logic       is_halt,
    output logic       is_illegal,
    output logic       updates_flag
);

    always_comb begin
        load         = 1'b0;
        clr_all      = 1'b0;
        wb_zero      = 1'b0;
        alu_op       = ALU_ADD;
        mb_select    = 1'b0;
        is_jump      = 1'b0;
        jump_cond    = JC_ALWAYS;
        is_halt      = 1'b0;
        is_illegal   = 1'b0;
        updates_flag = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                load         = 1'b1;
                alu_op       = op[2:0] - 3'd1;
                mb_select    = imm;
                updates_flag = 1'b1;
            end
            OP_MOV: begin
                load      = 1'b1;
                alu_op    = ALU_PASS_B;
                mb_select = imm;
            end
            OP_CLR: begin
                load    = 1'b1;
                wb_zero = 1'b1;
            end
            OP_CLRALL: clr_all = 1'b1;
            OP_JMP: is_jump = 1'b1;
            OP_JZ: begin
                is_jump   = 1'b1;
                jump_cond = JC_Z;
            end
            OP_JNZ: begin
                is_jump   = 1'b1;
                jump_cond = JC_NZ;
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Sequencer/decoder for the single-cycle processor: pc, IDLE/RUN/HALT FSM, zero and illegal flags.
// Optional single-step gating via `define CONTROL_UNIT_STEP_EN.
import ctrl_pkg::*;

module control_unit #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef CONTROL_UNIT_STEP_EN
    input  logic            step,
`endif
    input  logic [15:0]     instr,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      rf_addr_a,
    output logic [2:0]      rf_addr_b,
    output logic            rf_mb_select,
    output logic            rf_load,
    output logic            rf_clr_all,
    output logic            wb_zero,
    output logic [2:0]      alu_op,
    output logic            zero_flag,
    output logic            halted,
    output logic            illegal
);

    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

    state_t          state;
    logic            run_state;
    logic            exec;
    logic [PC_W-1:0] pc_next;
    logic            taken;

    logic       d_load, d_clr_all, d_wb_zero, d_mb_select;
    logic [2:0] d_alu_op;
    logic       d_is_jump, d_is_halt, d_is_illegal, d_updates_flag;
    logic [1:0] d_jump_cond;

    instr_decoder u_dec (
        .op           (instr[OP_MSB:OP_LSB]),
        .imm          (instr[IMM_BIT]),
        .load         (d_load),
        .clr_all      (d_clr_all),
        .wb_zero      (d_wb_zero),
        .alu_op       (d_alu_op),
        .mb_select    (d_mb_select),
        .is_jump      (d_is_jump),
        .jump_cond    (d_jump_cond),
        .is_halt      (d_is_halt),
        .is_illegal   (d_is_illegal),
        .updates_flag (d_updates_flag)
    );

    assign run_state = (state == S_RUN);
`ifdef CONTROL_UNIT_STEP_EN
    assign exec = run_state && step;
`else
    assign exec = run_state;
`endif

    assign rf_addr_a    = instr[RA_MSB:RA_LSB];
    assign rf_addr_b    = instr[RB_MSB:RB_LSB];
    assign rf_mb_select = run_state && d_mb_select;
    assign alu_op       = run_state ? d_alu_op : ALU_ADD;
    assign rf_load      = exec && d_load;
    assign rf_clr_all   = exec && d_clr_all;
    assign wb_zero      = exec && d_wb_zero;
    assign halted       = (state == S_HALT);

    always_comb begin
        taken = 1'b0;
        if (d_is_jump) begin
            case (d_jump_cond)
                JC_Z:    taken = zero_flag;
                JC_NZ:   taken = !zero_flag;
                default: taken = 1'b1;
            endcase
        end
        if (taken)
            pc_next = instr[PC_W-1:0];
        else if (d_is_halt)
            pc_next = pc;
        else
            pc_next = pc + PC_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= PC_INIT;
            zero_flag <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_RUN;
                S_RUN: if (exec) begin
                    pc <= pc_next;
                    if (d_is_halt) state <= S_HALT;
                    if (d_updates_flag) zero_flag <= alu_zero;
                    if (d_is_illegal) illegal <= 1'b1;
                end
                S_HALT: if (start) begin
                    state     <= S_RUN;
                    pc        <= PC_INIT;
                    zero_flag <= 1'b0;
                    illegal   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; ROM modelled as a combinational array.
`timescale 1ns/1ps
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b1;
    logic        alu_zero = 1'b0;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [2:0]  rf_addr_a, rf_addr_b, alu_op;
    logic        rf_mb_select, rf_load, rf_clr_all, wb_zero, zero_flag, halted, illegal;
    logic [15:0] rom [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign instr = rom[pc];

    control_unit #(.PC_W(8), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef CONTROL_UNIT_STEP_EN
        .step(step),
`endif
        .instr(instr), .alu_zero(alu_zero), .pc(pc),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_mb_select(rf_mb_select),
        .rf_load(rf_load), .rf_clr_all(rf_clr_all), .wb_zero(wb_zero), .alu_op(alu_op),
        .zero_flag(zero_flag), .halted(halted), .illegal(illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step  = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = 16'h12E0;
        do_reset();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
        checks++; if ({halted, illegal, zero_flag} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {halted, illegal, zero_flag}); end
        checks++; if ({rf_load, rf_clr_all, wb_zero, rf_mb_select, alu_op} !== 7'd0) begin errors++; $display("FAIL reset_writes: got %b want 0", {rf_load, rf_clr_all, wb_zero, rf_mb_select, alu_op}); end
        checks++; if ({rf_addr_a, rf_addr_b} !== 6'o13) begin errors++; $display("FAIL idle_addrs: got %o want 13", {rf_addr_a, rf_addr_b}); end
        tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL idle_hold: got %h want 00", pc); end
    endtask

    task automatic test_nop_wrap();
        logic load_seen;
        clear_rom();
        do_reset();
        start_run();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL first_pc: got %h want 00", pc); end
        tick();
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL pc_inc: got %h want 01", pc); end
        load_seen = 1'b0;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (rf_load) load_seen = 1'b1;
        end
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL pc_ff: got %h want ff", pc); end
        tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %h want 00", pc); end
        checks++; if (load_seen !== 1'b0) begin errors++; $display("FAIL nop_load: got %b want 0", load_seen); end
    endtask

    task automatic test_add();
        clear_rom();
        rom[0] = 16'h12E0;
        do_reset();
        start_run();
        checks++; if ({rf_addr_a, rf_addr_b, rf_mb_select, alu_op, rf_load} !== {3'd1, 3'd3, 1'b1, 3'd0, 1'b1}) begin
            errors++; $display("FAIL add_decode: got %b want %b", {rf_addr_a, rf_addr_b, rf_mb_select, alu_op, rf_load}, {3'd1, 3'd3, 1'b1, 3'd0, 1'b1}); end
        tick();
        checks++; if ({pc, rf_load, rf_mb_select} !== {8'h01, 2'b00}) begin errors++; $display("FAIL add_next: got %h/%b want 01/00", pc, {rf_load, rf_mb_select}); end
    endtask

    task automatic test_cond_jump(input logic [15:0] jop, input logic az, input logic [7:0] exp_pc, input logic exp_zf);
        clear_rom();
        rom[0] = 16'h2480;
        rom[1] = jop;
        alu_zero = az;
        do_reset();
        start_run();
        checks++; if (alu_op !== 3'd1) begin errors++; $display("FAIL sub_aluop: got %0d want 1", alu_op); end
        tick();
        alu_zero = 1'b0;
        checks++; if (zero_flag !== exp_zf) begin errors++; $display("FAIL flag_after_sub: got %b want %b", zero_flag, exp_zf); end
        tick();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL jump_pc op=%h: got %h want %h", jop, pc, exp_pc); end
    endtask

    task automatic test_clr_halt();
        clear_rom();
        rom[0] = 16'h7A00;
        rom[1] = 16'h8000;
        rom[2] = 16'hF000;
        do_reset();
        start_run();
        checks++; if ({rf_load, wb_zero, rf_clr_all, rf_addr_a} !== {3'b110, 3'd5}) begin errors++; $display("FAIL clr: got %b want 110101", {rf_load, wb_zero, rf_clr_all, rf_addr_a}); end
        tick();
        checks++; if ({rf_clr_all, rf_load, wb_zero} !== 3'b100) begin errors++; $display("FAIL clrall: got %b want 100", {rf_clr_all, rf_load, wb_zero}); end
        tick();
        checks++; if ({pc, halted} !== {8'h02, 1'b0}) begin errors++; $display("FAIL halt_fetch: got %h/%b want 02/0", pc, halted); end
        tick();
        tick();
        checks++; if ({pc, halted, rf_load, alu_op} !== {8'h02, 1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL halted: got %h/%b want 02/1000", pc, {halted, rf_load, alu_op}); end
        start_run();
        checks++; if ({pc, halted, rf_load} !== {8'h00, 2'b01}) begin errors++; $display("FAIL restart: got %h/%b want 00/01", pc, {halted, rf_load}); end
    endtask

    task automatic test_illegal();
        clear_rom();
        rom[0] = 16'hD000;
        rom[1] = 16'h2480;
        rom[2] = 16'hF000;
        do_reset();
        start_run();
        checks++; if (rf_load !== 1'b0) begin errors++; $display("FAIL illegal_nop: got %b want 0", rf_load); end
        tick();
        alu_zero = 1'b1;
        checks++; if ({pc, illegal} !== {8'h01, 1'b1}) begin errors++; $display("FAIL illegal_set: got %h/%b want 01/1", pc, illegal); end
        tick();
        alu_zero = 1'b0;
        tick();
        checks++; if ({halted, illegal, zero_flag} !== 3'b111) begin errors++; $display("FAIL illegal_sticky: got %b want 111", {halted, illegal, zero_flag}); end
        start_run();
        checks++; if ({illegal, zero_flag, pc} !== {2'b00, 8'h00}) begin errors++; $display("FAIL restart_clear: got %b/%h want 00/00", {illegal, zero_flag}, pc); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        reset = 1'b0;
    endtask

    task automatic test_reset_midrun();
        clear_rom();
        rom[7] = 16'h12E0;
        do_reset();
        start_run();
        for (int i = 0; i < 7; i++) tick();
        checks++; if ({pc, rf_load} !== {8'h07, 1'b1}) begin errors++; $display("FAIL pre_reset: got %h/%b want 07/1", pc, rf_load); end
        reset = 1'b1;
        #1;
        checks++; if ({pc, rf_load, rf_mb_select, alu_op, halted} !== {8'h00, 6'd0}) begin errors++; $display("FAIL async_reset: got %h/%b want 00/0", pc, {rf_load, rf_mb_select, alu_op, halted}); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL idle_after_reset: got %h want 00", pc); end
    endtask

`ifdef CONTROL_UNIT_STEP_EN
    task automatic test_step();
        clear_rom();
        rom[0] = 16'h12E0;
        do_reset();
        step = 1'b0;
        start_run();
        checks++; if (rf_load !== 1'b0) begin errors++; $display("FAIL step_load: got %b want 0", rf_load); end
        tick();
        tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL step_hold: got %h want 00", pc); end
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL step_pulse: got %h want 01", pc); end
        step = 1'b1;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_nop_wrap();
        test_add();
        test_cond_jump(16'hA010, 1'b1, 8'h10, 1'b1);
        test_cond_jump(16'hA010, 1'b0, 8'h02, 1'b0);
        test_cond_jump(16'hB010, 1'b0, 8'h10, 1'b0);
        test_clr_halt();
        test_illegal();
        test_reset_midrun();
`ifdef CONTROL_UNIT_STEP_EN
        test_step();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencer and decoder that drives the 8-register, 8-bit register file of the single-cycle processor. It holds the program counter and fetches one 16-bit instruction per cycle from the instruction ROM. It generates the register-file addresses, write enable, immediate select and ALU operation. It also keeps the ALU zero flag for conditional jumps and runs a small IDLE/RUN/HALT state machine.

## Interface
Parameters:
- PC_W, 8, program counter width (ROM depth 2^PC_W)
- RESET_PC, 0, PC value after reset and on restart

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  level; IDLE/HALT -> RUN
- instr  in  16  ROM data at address pc (combinational ROM)
- alu_zero  in  1  combinational zero output of ALU for current op
- pc  out  PC_W  instruction address
- rf_addr_a  out  3  register file addr_a (destination / operand A)
- rf_addr_b  out  3  register file addr_b (operand B or 3-bit immediate)
- rf_mb_select  out  1  1 = addr_b used as immediate
- rf_load  out  1  register write enable
- rf_clr_all  out  1  synchronous clear of all registers
- wb_zero  out  1  write-back mux selects 8'h00 instead of ALU result
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
- zero_flag  out  1  registered zero flag
- halted  out  1  state == HALT
- illegal  out  1  sticky, set on undefined opcode

## Operation
- Format: op = instr[15:12], ra = instr[11:9], rb = instr[8:6], imm = instr[5], target = instr[PC_W-1:0].
- Opcodes:
  - 0 NOP
  - 1–5 ADD/SUB/AND/OR/XOR: ra <= ra op (rb or imm); load=1; zero_flag updated.
  - 6 MOV: ra <= rb or imm (PASS_B); load=1; flag unchanged.
  - 7 CLR: load=1, wb_zero=1, ra <= 0.
  - 8 CLRALL: rf_clr_all=1.
  - 9 JMP
  - A JZ: taken if zero_flag=1.
  - B JNZ: taken if zero_flag=0.
  - F HALT
  - C–E illegal: executed as NOP, and illegal is set.
- rf_mb_select = imm for opcodes 1–6; otherwise 0.
- Register-file asynchronous reset is never driven. CLR uses the synchronous load path so that address glitches are harmless.
- FSM:
  - IDLE: reset state; pc = RESET_PC. Goes to RUN when start=1.
  - RUN: executes instr each cycle. Opcode F goes to HALT.
  - HALT: pc frozen. start=1 goes to RUN with pc = RESET_PC, zero_flag cleared, illegal cleared.
- Write-side outputs (rf_load, rf_clr_all, wb_zero) are asserted only in RUN. In IDLE/HALT they are 0 and alu_op=0.
- pc next value:
  - Taken jump: target.
  - HALT instruction: pc (hold).
  - Otherwise: pc+1, wrapping 2^PC_W-1 -> 0.

## Timing
- Reset values: pc=RESET_PC, state IDLE, zero_flag=0, illegal=0, halted=0, all rf_* and wb_zero = 0, alu_op=0. rf_addr_a/rf_addr_b follow instr fields even in IDLE.
- Decode is combinational from instr. One instruction completes per cycle in RUN.
- Register write, pc update and zero_flag update all occur at the same rising edge.
- A conditional jump immediately after an ALU op sees the flag produced by that op, because the flag is registered at the op's edge.
- The first instruction at RESET_PC executes in the first cycle after the IDLE->RUN edge. start is sampled only in IDLE/HALT.
- reset mid-RUN: asynchronous return to reset values. An in-flight write is discarded because rf_load drops with reset.
- illegal is sticky; it is cleared only by reset or a HALT restart.

## Configuration
- CONTROL_UNIT_STEP_EN defined: adds input step (1 bit). In RUN, an instruction executes only on cycles with step=1. On other cycles:
  - pc, zero_flag and state hold.
  - rf_load, rf_clr_all and wb_zero are 0.
  - HALT detection also requires step=1.
- Not defined: no step port; RUN executes every cycle.

## Structure
- ctrl_pkg:
  - opcode localparams (OP_NOP … OP_HALT)
  - alu_op encoding
  - state enum (S_IDLE, S_RUN, S_HALT)
  - instruction field bit positions
- Sub-module instr_decoder: purely combinational. Maps op/imm to load, clr_all, wb_zero, alu_op, mb_select, is_jump, jump_cond, is_halt, is_illegal, updates_flag.
- control_unit contains the FSM, pc register, zero_flag and illegal registers.

## Test plan
- Reset then start=1, ROM holds NOPs -> pc increments 0,1,2…; from 0xFF, pc wraps to 0x00; rf_load stays 0.
- ROM[0]=ADD r1,imm3 (0x1 2 E0 form: op1, ra1, rb3, imm1) -> rf_addr_a=1, rf_addr_b=3, rf_mb_select=1, alu_op=0, rf_load=1 for one cycle.
- ROM[0]=SUB r2,r2 with alu_zero=1, ROM[1]=JZ 0x10 -> zero_flag=1 after edge 1; pc=0x10 after edge 2. Same program with alu_zero=0 -> pc=2.
- ROM[0]=CLR r5, ROM[1]=CLRALL, ROM[2]=HALT -> load=1/wb_zero=1/addr_a=5, then rf_clr_all=1, then halted=1 with pc stuck at 2. start=1 -> pc=0, RUN.
- ROM[0]=opcode 0xD -> behaves as NOP; illegal=1 and stays 1 until HALT restart or reset.
- Assert reset mid-RUN at pc=7 -> pc=0, IDLE, all write outputs 0 immediately. With CONTROL_UNIT_STEP_EN: step=0 -> pc holds; a 1-cycle step pulse -> pc advances by exactly 1.
